adapter_ppfifo_2_axi_stream: RTL and testbench

//  Read-side counterpart of the AXI-stream-to-PPFIFO write adapter. Drains one

---
 rtl/adapter_ppfifo_2_axi_stream.sv | 166 ++++++++++++++++
 tb/tb_adapter_ppfifo_2_axi_stream.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adapter_ppfifo_2_axi_stream.sv
// Ping Pong FIFO read-block to AXI stream adapter: drains one read block per
// activation, with a 2-entry output skid buffer covering the 1-cycle read latency.
module adapter_ppfifo_2_axi_stream #(
  parameter int DATA_WIDTH   = 32,
  parameter int STROBE_WIDTH = DATA_WIDTH / 8
) (
  input  logic                    i_axi_clk,
  input  logic                    rst,

  output logic                    o_ppfifo_clk,
  input  logic                    i_ppfifo_rdy,
  output logic                    o_ppfifo_act,
  input  logic [23:0]             i_ppfifo_size,
  output logic                    o_ppfifo_stb,
  input  logic [DATA_WIDTH-1:0]   i_ppfifo_data,

  output logic                    o_axi_valid,
  input  logic                    i_axi_ready,
  output logic [DATA_WIDTH-1:0]   o_axi_data,
  output logic [STROBE_WIDTH-1:0] o_axi_keep,
  output logic                    o_axi_last
);

  typedef enum logic [1:0] {
    IDLE,
    READY,
    RELEASE
  } state_t;

  state_t                  state_q, state_d;
  logic                    act_q, act_d;
  logic                    stb_q, stb_d;
  logic [23:0]             size_q, size_d;
  logic [23:0]             issue_q, issue_d;
  logic [23:0]             recv_q, recv_d;

  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [STROBE_WIDTH-1:0] keep_q, keep_d;
  logic                    skid_valid_q, skid_valid_d;
  logic                    skid_last_q, skid_last_d;
  logic [DATA_WIDTH-1:0]   skid_data_q, skid_data_d;

  logic                    pop;
  logic                    in_last;
  logic [1:0]              occ;

  assign o_ppfifo_clk = i_axi_clk;
  assign o_ppfifo_act = act_q;
  assign o_ppfifo_stb = stb_q;
  assign o_axi_valid  = out_valid_q;
  assign o_axi_data   = out_data_q;
  assign o_axi_last   = out_last_q;
  assign o_axi_keep   = keep_q;

  assign pop     = out_valid_q && i_axi_ready;
  // recv_q indexes the word arriving this cycle (popped by last cycle's stb)
  assign in_last = (recv_q == (size_q - 24'd1));
  assign occ     = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(stb_q);

  // Output register plus one skid slot; the skid only fills while the output stalls.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_last_d  = skid_last_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || pop) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_last_d   = skid_last_q;
        out_data_d   = skid_data_q;
        skid_valid_d = stb_q;
        if (stb_q) begin
          skid_last_d = in_last;
          skid_data_d = i_ppfifo_data;
        end
      end else if (stb_q) begin
        out_valid_d = 1'b1;
        out_last_d  = in_last;
        out_data_d  = i_ppfifo_data;
      end else begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    end else if (stb_q) begin
      skid_valid_d = 1'b1;
      skid_last_d  = in_last;
      skid_data_d  = i_ppfifo_data;
    end
    keep_d = out_valid_d ? '1 : '0;
  end

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    stb_d   = 1'b0;
    size_d  = size_q;
    issue_d = issue_q;
    recv_d  = recv_q;
    case (state_q)
      IDLE: begin
        act_d = 1'b0;
        if (i_ppfifo_rdy && !act_q) begin
          act_d   = 1'b1;
          size_d  = i_ppfifo_size;
          issue_d = '0;
          recv_d  = '0;
          state_d = (i_ppfifo_size == 24'd0) ? RELEASE : READY;
        end
      end
      READY: begin
        if (stb_q) recv_d = recv_q + 24'd1;
        if ((issue_q < size_q) && ((occ - 2'(pop)) < 2'd2)) begin
          stb_d   = 1'b1;
          issue_d = issue_q + 24'd1;
        end
        if ((issue_q == size_q) && !stb_q && !out_valid_d && !skid_valid_d)
          state_d = RELEASE;
      end
      RELEASE: begin
        act_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        act_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_axi_clk) begin
    if (rst) begin
      state_q      <= IDLE;
      act_q        <= 1'b0;
      stb_q        <= 1'b0;
      size_q       <= '0;
      issue_q      <= '0;
      recv_q       <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      keep_q       <= '0;
      skid_valid_q <= 1'b0;
      skid_last_q  <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      act_q        <= act_d;
      stb_q        <= stb_d;
      size_q       <= size_d;
      issue_q      <= issue_d;
      recv_q       <= recv_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_data_q   <= out_data_d;
      keep_q       <= keep_d;
      skid_valid_q <= skid_valid_d;
      skid_last_q  <= skid_last_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: tb/tb_adapter_ppfifo_2_axi_stream.sv
// Bench for adapter_ppfifo_2_axi_stream: a behavioural PPFIFO serves random
// blocks, a monitor records every beat, and each test compares against the block contents.
module tb_adapter_ppfifo_2_axi_stream;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rdy = 1'b0;
  logic          ready = 1'b0;
  logic [23:0]   size = '0;
  logic [DW-1:0] pdata;
  logic          ppclk, act, stb, valid, last;
  logic [DW-1:0] adata;
  logic [SW-1:0] keep;

  int checks = 0;
  int errors = 0;

  // PPFIFO model: current block contents, head word presented while popping
  logic [DW-1:0] pp_mem [1024];
  int pp_base = 0;
  int total_pops = 0;

  // Monitor state (written only by the monitor)
  int cyc = 0, act_cycles = 0, outstanding = 0;
  int occ_viol = 0, stall_viol = 0, keep_viol = 0, last_viol = 0;
  logic [DW-1:0] beat_data [$];
  logic          beat_last [$];
  int            beat_cyc  [$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  logic [SW-1:0] prev_keep = '0;

  assign pdata = pp_mem[(total_pops - pp_base) & 1023];

  adapter_ppfifo_2_axi_stream #(.DATA_WIDTH(DW), .STROBE_WIDTH(SW)) dut (
    .i_axi_clk    (clk),
    .rst          (rst),
    .o_ppfifo_clk (ppclk),
    .i_ppfifo_rdy (rdy),
    .o_ppfifo_act (act),
    .i_ppfifo_size(size),
    .o_ppfifo_stb (stb),
    .i_ppfifo_data(pdata),
    .o_axi_valid  (valid),
    .i_axi_ready  (ready),
    .o_axi_data   (adata),
    .o_axi_keep   (keep),
    .o_axi_last   (last)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    if (prev_stall && (!valid || adata !== prev_data || last !== prev_last || keep !== prev_keep))
      stall_viol <= stall_viol + 1;
    if (!rst && (outstanding + int'(stb)) > 2) occ_viol <= occ_viol + 1;
    if (valid ? (keep !== {SW{1'b1}}) : (keep !== {SW{1'b0}})) keep_viol <= keep_viol + 1;
    if (last && !valid) last_viol <= last_viol + 1;
    if (act) act_cycles <= act_cycles + 1;
    if (stb) total_pops <= total_pops + 1;
    if (valid && ready && !rst) begin
      beat_data.push_back(adata);
      beat_last.push_back(last);
      beat_cyc.push_back(cyc);
    end
    outstanding <= rst ? 0 : outstanding + int'(stb) - int'(valid && ready);
    prev_stall  <= valid && !ready && !rst;
    prev_data   <= adata;
    prev_last   <= last;
    prev_keep   <= keep;
    cyc         <= cyc + 1;
  end

  function automatic logic pick_ready(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 2) == 0;
      default: return ($urandom % 4) != 0;
    endcase
  endfunction

  // Stimulus only: offers one block of n random words and waits for act to drop.
  task automatic drive_block(input int n, input int mode, input int budget, output bit tmo);
    int k;
    for (int i = 0; i < n; i++) pp_mem[i] = $urandom;
    pp_base = total_pops;
    size    = 24'(n);
    rdy     = 1'b1;
    k       = 0;
    ready   = pick_ready(mode, k);
    while (!act && k < budget) begin
      @(posedge clk); #1;
      k++;
      ready = pick_ready(mode, k);
    end
    rdy = 1'b0;
    while (act && k < budget) begin
      @(posedge clk); #1;
      k++;
      ready = pick_ready(mode, k);
    end
    tmo = (k >= budget);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (act !== 1'b0)   begin errors++; $display("FAIL reset_act got %b want 0", act); end
    checks++; if (stb !== 1'b0)   begin errors++; $display("FAIL reset_stb got %b want 0", stb); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (last !== 1'b0)  begin errors++; $display("FAIL reset_last got %b want 0", last); end
    checks++; if (adata !== '0)   begin errors++; $display("FAIL reset_data got %h want 0", adata); end
    checks++; if (keep !== '0)    begin errors++; $display("FAIL reset_keep got %h want 0", keep); end
  endtask

  task automatic test_basic();
    bit tmo;
    int s, p0, a0, o0;
    s = beat_data.size(); p0 = total_pops; a0 = act_cycles; o0 = occ_viol;
    drive_block(4, 0, 100, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL basic_timeout got 1 want 0"); end
    checks++; if (beat_data.size() - s != 4) begin errors++; $display("FAIL basic_beats got %0d want 4", beat_data.size() - s); end
    checks++; if (total_pops - p0 != 4) begin errors++; $display("FAIL basic_stb got %0d want 4", total_pops - p0); end
    // act rises, 3-cycle fill latency, n beats, then one RELEASE cycle
    checks++; if (act_cycles - a0 != 7) begin errors++; $display("FAIL basic_act_cycles got %0d want 7", act_cycles - a0); end
    checks++; if (occ_viol != o0) begin errors++; $display("FAIL basic_occupancy got %0d want %0d", occ_viol, o0); end
    for (int i = 0; i < 4 && s + i < beat_data.size(); i++) begin
      checks++; if (beat_data[s+i] !== pp_mem[i]) begin errors++; $display("FAIL basic_data[%0d] got %h want %h", i, beat_data[s+i], pp_mem[i]); end
      checks++; if (beat_last[s+i] !== (i == 3)) begin errors++; $display("FAIL basic_last[%0d] got %b want %b", i, beat_last[s+i], i == 3); end
    end
  endtask

  task automatic test_stall();
    bit tmo;
    int s, o0, st0;
    s = beat_data.size(); o0 = occ_viol; st0 = stall_viol;
    drive_block(8, 1, 200, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL stall_timeout got 1 want 0"); end
    checks++; if (beat_data.size() - s != 8) begin errors++; $display("FAIL stall_beats got %0d want 8", beat_data.size() - s); end
    checks++; if (occ_viol != o0) begin errors++; $display("FAIL stall_occupancy got %0d want %0d", occ_viol, o0); end
    checks++; if (stall_viol != st0) begin errors++; $display("FAIL stall_hold got %0d want %0d", stall_viol, st0); end
    for (int i = 0; i < 8 && s + i < beat_data.size(); i++) begin
      checks++; if (beat_data[s+i] !== pp_mem[i]) begin errors++; $display("FAIL stall_data[%0d] got %h want %h", i, beat_data[s+i], pp_mem[i]); end
      checks++; if (beat_last[s+i] !== (i == 7)) begin errors++; $display("FAIL stall_last[%0d] got %b want %b", i, beat_last[s+i], i == 7); end
    end
  endtask

  task automatic test_single();
    bit tmo;
    int s, a0, k0;
    s = beat_data.size(); a0 = act_cycles; k0 = keep_viol;
    drive_block(1, 0, 100, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL single_timeout got 1 want 0"); end
    checks++; if (beat_data.size() - s != 1) begin errors++; $display("FAIL single_beats got %0d want 1", beat_data.size() - s); end
    checks++; if (act_cycles - a0 != 4) begin errors++; $display("FAIL single_act_cycles got %0d want 4", act_cycles - a0); end
    checks++; if (keep_viol != k0) begin errors++; $display("FAIL single_keep got %0d want %0d", keep_viol, k0); end
    if (beat_data.size() > s) begin
      checks++; if (beat_data[s] !== pp_mem[0]) begin errors++; $display("FAIL single_data got %h want %h", beat_data[s], pp_mem[0]); end
      checks++; if (beat_last[s] !== 1'b1) begin errors++; $display("FAIL single_last got %b want 1", beat_last[s]); end
    end
  endtask

  task automatic test_zero();
    bit tmo;
    int s, p0, a0;
    s = beat_data.size(); p0 = total_pops; a0 = act_cycles;
    drive_block(0, 0, 50, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL zero_timeout got 1 want 0"); end
    checks++; if (total_pops != p0) begin errors++; $display("FAIL zero_stb got %0d want 0", total_pops - p0); end
    checks++; if (beat_data.size() != s) begin errors++; $display("FAIL zero_beats got %0d want 0", beat_data.size() - s); end
    checks++; if (act_cycles - a0 != 1) begin errors++; $display("FAIL zero_act_cycles got %0d want 1", act_cycles - a0); end
    @(posedge clk); #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL zero_valid got %b want 0", valid); end
  endtask

  task automatic test_back_to_back();
    bit tmo;
    int s;
    s = beat_data.size();
    for (int b = 0; b < 2; b++) begin
      drive_block(256, 0, 1000, tmo);
      checks++; if (tmo) begin errors++; $display("FAIL b2b_timeout[%0d] got 1 want 0", b); end
      checks++; if (beat_data.size() - s != 256 * (b + 1)) begin errors++; $display("FAIL b2b_beats[%0d] got %0d want %0d", b, beat_data.size() - s, 256 * (b + 1)); end
      for (int i = 0; i < 256 && s + 256 * b + i < beat_data.size(); i++) begin
        checks++; if (beat_data[s+256*b+i] !== pp_mem[i]) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", 256*b+i, beat_data[s+256*b+i], pp_mem[i]); end
        checks++; if (beat_last[s+256*b+i] !== (i == 255)) begin errors++; $display("FAIL b2b_last[%0d] got %b want %b", 256*b+i, beat_last[s+256*b+i], i == 255); end
      end
    end
    if (beat_data.size() - s >= 257) begin
      checks++;
      if (beat_cyc[s+256] - beat_cyc[s+255] > 5) begin
        errors++; $display("FAIL b2b_gap got %0d idle clks want <=4", beat_cyc[s+256] - beat_cyc[s+255] - 1);
      end
    end
  endtask

  task automatic test_random();
    bit tmo;
    int s, n, o0, st0;
    for (int b = 0; b < 8; b++) begin
      n = $urandom_range(0, 20);
      s = beat_data.size(); o0 = occ_viol; st0 = stall_viol;
      drive_block(n, 2, 40 * n + 50, tmo);
      checks++; if (tmo) begin errors++; $display("FAIL rand_timeout[%0d] got 1 want 0", b); end
      checks++; if (beat_data.size() - s != n) begin errors++; $display("FAIL rand_beats[%0d] got %0d want %0d", b, beat_data.size() - s, n); end
      checks++; if (occ_viol != o0 || stall_viol != st0) begin errors++; $display("FAIL rand_rules[%0d] got occ=%0d hold=%0d want occ=%0d hold=%0d", b, occ_viol, stall_viol, o0, st0); end
      for (int i = 0; i < n && s + i < beat_data.size(); i++) begin
        checks++; if (beat_data[s+i] !== pp_mem[i]) begin errors++; $display("FAIL rand_data[%0d][%0d] got %h want %h", b, i, beat_data[s+i], pp_mem[i]); end
        checks++; if (beat_last[s+i] !== (i == n - 1)) begin errors++; $display("FAIL rand_last[%0d][%0d] got %b want %b", b, i, beat_last[s+i], i == n - 1); end
      end
    end
  endtask

  task automatic test_mid_reset();
    bit tmo;
    int s, k;
    s = beat_data.size();
    for (int i = 0; i < 8; i++) pp_mem[i] = $urandom;
    pp_base = total_pops;
    size = 24'd8; rdy = 1'b1; ready = 1'b1; k = 0;
    while (!act && k < 50) begin @(posedge clk); #1; k++; end
    rdy = 1'b0;
    while (beat_data.size() - s < 3 && k < 50) begin @(posedge clk); #1; k++; end
    checks++; if (beat_data.size() - s != 3) begin errors++; $display("FAIL mrst_pre_beats got %0d want 3", beat_data.size() - s); end
    for (int i = 0; i < 3 && s + i < beat_data.size(); i++) begin
      checks++; if (beat_data[s+i] !== pp_mem[i]) begin errors++; $display("FAIL mrst_pre_data[%0d] got %h want %h", i, beat_data[s+i], pp_mem[i]); end
    end
    ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (act !== 1'b0)   begin errors++; $display("FAIL mrst_act got %b want 0", act); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mrst_valid got %b want 0", valid); end
    checks++; if (last !== 1'b0)  begin errors++; $display("FAIL mrst_last got %b want 0", last); end
    checks++; if (stb !== 1'b0)   begin errors++; $display("FAIL mrst_stb got %b want 0", stb); end
    s = beat_data.size();
    drive_block(2, 0, 100, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL mrst_post_timeout got 1 want 0"); end
    checks++; if (beat_data.size() - s != 2) begin errors++; $display("FAIL mrst_post_beats got %0d want 2", beat_data.size() - s); end
    for (int i = 0; i < 2 && s + i < beat_data.size(); i++) begin
      checks++; if (beat_data[s+i] !== pp_mem[i]) begin errors++; $display("FAIL mrst_post_data[%0d] got %h want %h", i, beat_data[s+i], pp_mem[i]); end
      checks++; if (beat_last[s+i] !== (i == 1)) begin errors++; $display("FAIL mrst_post_last[%0d] got %b want %b", i, beat_last[s+i], i == 1); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_single();
    test_zero();
    test_back_to_back();
    test_random();
    test_mid_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (keep_viol != 0) begin errors++; $display("FAIL keep_rule got %0d violations want 0", keep_viol); end
    checks++; if (last_viol != 0) begin errors++; $display("FAIL last_without_valid got %0d want 0", last_viol); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
